// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: register widths, load/store type codes,
// FSM state encodings and the byte-count helper used to size serial accesses.
package mem_stage_pkg;

    localparam int RegLen     = 32;
    localparam int RegAddrLen = 5;
    localparam int OpCodeLen  = 4;
    localparam int CntLen     = 2;

    typedef enum logic [OpCodeLen-1:0] {
        LS_NOP = 4'd0,
        LS_LB  = 4'd1,
        LS_LH  = 4'd2,
        LS_LW  = 4'd3,
        LS_LBU = 4'd4,
        LS_LHU = 4'd5,
        LS_SB  = 4'd6,
        LS_SH  = 4'd7,
        LS_SW  = 4'd8
    } ls_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_LAST   = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_e;

    // Index of the final byte of an access (N-1); unknown codes fall back to one byte.
    function automatic logic [CntLen-1:0] lastByteIdx(input logic [OpCodeLen-1:0] lsType);
        logic [CntLen-1:0] idx;
        case (lsType)
            LS_LH, LS_LHU, LS_SH: idx = 2'd1;
            LS_LW, LS_SW:         idx = 2'd3;
            default:              idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load result formatter: sign- or zero-extends the assembled little-endian buffer
// according to the load type.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [RegLen-1:0]    i_buffer,
    input  logic [OpCodeLen-1:0] i_type,
    output logic [RegLen-1:0]    o_result
);

    always_comb begin
        o_result = i_buffer;
        case (i_type)
            LS_LB:   o_result = {{24{i_buffer[7]}}, i_buffer[7:0]};
            LS_LH:   o_result = {{16{i_buffer[15]}}, i_buffer[15:0]};
            LS_LBU:  o_result = {24'h000000, i_buffer[7:0]};
            LS_LHU:  o_result = {16'h0000, i_buffer[15:0]};
            LS_LW:   o_result = i_buffer;
            default: o_result = i_buffer;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: serialises loads and stores over a byte-wide arbitrated RAM,
// stalling the pipeline until the access completes.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic [RegLen-1:0]     rd_data_i,
    input  logic [RegAddrLen-1:0] rd_addr_i,
    input  logic                  rd_enable_i,

    input  logic                  load_enable_i,
    input  logic                  store_enable_i,
    input  logic [RegLen-1:0]     mem_addr_i,
    input  logic [OpCodeLen-1:0]  load_store_type_i,

    output logic [RegLen-1:0]     rd_data_o,
    output logic [RegAddrLen-1:0] rd_addr_o,
    output logic                  rd_enable_o,

    output logic                  ram_req_o,
    input  logic                  ram_grant_i,
    output logic [RegLen-1:0]     ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i,

    output logic                  stall_req_o
);

    mem_state_e          r_state;
    logic [CntLen-1:0]   r_cnt;
    logic [RegLen-1:0]   r_buffer;

    logic                w_op;
    logic [CntLen-1:0]   w_lastIdx;
    logic [CntLen-1:0]   w_prevIdx;
    logic [RegLen-1:0]   w_extData;
    logic [RegLen-1:0]   w_byteAddr;

    assign w_op       = load_enable_i | store_enable_i;
    assign w_lastIdx  = lastByteIdx(load_store_type_i);
    assign w_prevIdx  = r_cnt - 2'd1;
    assign w_byteAddr = mem_addr_i + {{(RegLen-CntLen){1'b0}}, r_cnt};

    load_ext u_load_ext (
        .i_buffer (r_buffer),
        .i_type   (load_store_type_i),
        .o_result (w_extData)
    );

    // RAM read data lags its address by a cycle, so byte k lands while byte k+1 is
    // being addressed; LAST exists only to collect the final byte of a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_buffer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_op && ram_grant_i) begin
                        r_state  <= ST_ACCESS;
                        r_cnt    <= '0;
                        r_buffer <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (load_enable_i && (r_cnt != 2'd0)) begin
                        r_buffer[{w_prevIdx, 3'b000} +: 8] <= ram_din_i;
                    end
                    if (r_cnt == w_lastIdx) begin
                        r_cnt <= '0;
                        if (store_enable_i) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_LAST;
                        end
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_LAST: begin
                    r_buffer[{w_lastIdx, 3'b000} +: 8] <= ram_din_i;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs follow the state directly so that IDLE pass-through and the first
    // request happen in the same cycle the instruction arrives.
    always_comb begin
        rd_data_o   = '0;
        rd_addr_o   = '0;
        rd_enable_o = 1'b0;
        ram_req_o   = 1'b0;
        ram_addr_o  = '0;
        ram_wr_o    = 1'b0;
        ram_dout_o  = '0;
        stall_req_o = 1'b0;
        if (rst) begin
            ram_addr_o = w_byteAddr;
            case (r_state)
                ST_IDLE: begin
                    if (w_op) begin
                        ram_req_o   = 1'b1;
                        stall_req_o = 1'b1;
                    end else begin
                        rd_data_o   = rd_data_i;
                        rd_addr_o   = rd_addr_i;
                        rd_enable_o = rd_enable_i;
                    end
                end
                ST_ACCESS: begin
                    ram_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                    ram_wr_o    = store_enable_i;
                    ram_dout_o  = rd_data_i[{r_cnt, 3'b000} +: 8];
                end
                ST_LAST: begin
                    ram_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                end
                ST_DONE: begin
                    rd_addr_o = rd_addr_i;
                    if (store_enable_i) begin
                        rd_data_o   = rd_data_i;
                        rd_enable_o = 1'b0;
                    end else begin
                        rd_data_o   = w_extData;
                        rd_enable_o = rd_enable_i;
                    end
                end
                default: begin
                    rd_enable_o = 1'b0;
                end
            endcase
        end
    end

    a_noEnableWhileStalled: assert property (@(posedge clk) disable iff (!rst)
        stall_req_o |-> !rd_enable_o);

    a_writeOnlyWithRequest: assert property (@(posedge clk) disable iff (!rst)
        ram_wr_o |-> ram_req_o);

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: byte-wide RAM model with one-cycle read latency,
// per-scenario tasks with hand-computed expectations.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_enable_i;
    logic        load_enable_i;
    logic        store_enable_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  load_store_type_i;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;
    logic        ram_req_o;
    logic        ram_grant_i;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ramDin = 8'h00;
    logic        stall_req_o;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ramMem [logic [31:0]];
    logic [31:0] writeAddr [0:31];
    logic [7:0]  writeData [0:31];
    int          writeCount = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .rd_data_i         (rd_data_i),
        .rd_addr_i         (rd_addr_i),
        .rd_enable_i       (rd_enable_i),
        .load_enable_i     (load_enable_i),
        .store_enable_i    (store_enable_i),
        .mem_addr_i        (mem_addr_i),
        .load_store_type_i (load_store_type_i),
        .rd_data_o         (rd_data_o),
        .rd_addr_o         (rd_addr_o),
        .rd_enable_o       (rd_enable_o),
        .ram_req_o         (ram_req_o),
        .ram_grant_i       (ram_grant_i),
        .ram_addr_o        (ram_addr_o),
        .ram_wr_o          (ram_wr_o),
        .ram_dout_o        (ram_dout_o),
        .ram_din_i         (ramDin),
        .stall_req_o       (stall_req_o)
    );

    // Fixed background contents for locations the bench never writes.
    function automatic logic [7:0] romByte(input logic [31:0] addr);
        case (addr)
            32'h0000_0200: return 8'h80;
            32'hFFFF_FFFF: return 8'h34;
            32'h0000_0000: return 8'h92;
            32'h0000_0300: return 8'h11;
            32'h0000_0301: return 8'h22;
            32'h0000_0302: return 8'h33;
            32'h0000_0303: return 8'h84;
            default:       return 8'h00;
        endcase
    endfunction

    // RAM model: read data registered one cycle after the address, writes logged in order.
    always @(posedge clk) begin
        ramDin <= ramMem.exists(ram_addr_o) ? ramMem[ram_addr_o] : romByte(ram_addr_o);
        if (ram_req_o && ram_wr_o) begin
            ramMem[ram_addr_o] = ram_dout_o;
            if (writeCount < 32) begin
                writeAddr[writeCount] = ram_addr_o;
                writeData[writeCount] = ram_dout_o;
            end
            writeCount++;
        end
    end

    task automatic applyStimulus(input logic ld, input logic st, input logic [3:0] typ,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rdAddr, input logic rdEn, input logic grant);
        load_enable_i     = ld;
        store_enable_i    = st;
        load_store_type_i = typ;
        mem_addr_i        = addr;
        rd_data_i         = data;
        rd_addr_i         = rdAddr;
        rd_enable_i       = rdEn;
        ram_grant_i       = grant;
    endtask

    task automatic idle();
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, LS_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    // Counts stalled cycles from the current one and captures the first unstalled cycle.
    task automatic waitDone(output int stalls, output logic [31:0] data,
                            output logic [4:0] addrOut, output logic en, output logic timedOut);
        stalls   = 0;
        timedOut = 1'b1;
        data     = '0;
        addrOut  = '0;
        en       = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_req_o) begin
                stalls++;
            end else begin
                data     = rd_data_o;
                addrOut  = rd_addr_o;
                en       = rd_enable_o;
                timedOut = 1'b0;
                break;
            end
        end
        checks++;
        if (timedOut !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_timeout actual=%0d expected=0", timedOut);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, LS_LW, 32'h300, 32'hDEADBEEF, 5'd9, 1'b1, 1'b1);
        #2;
        checks++;
        if (rd_data_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd_data actual=%h expected=%h", rd_data_o, 32'h0); end
        checks++;
        if (rd_enable_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_enable actual=%b expected=0", rd_enable_o); end
        checks++;
        if (ram_req_o !== 1'b0 || stall_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_stall actual=%b%b expected=00", ram_req_o, stall_req_o); end
        checks++;
        if (ram_addr_o !== 32'h0 || ram_wr_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ram_bus actual=%h/%b expected=0/0", ram_addr_o, ram_wr_o); end
        @(posedge clk);
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, LS_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b0, LS_NOP, 32'h0, 32'h1234, 5'd5, 1'b1, 1'b0);
        #1;
        checks++;
        if (rd_data_o !== 32'h1234 || rd_addr_o !== 5'd5) begin failures++; $display("[TB] FAIL pass_data actual=%h/%0d expected=1234/5", rd_data_o, rd_addr_o); end
        checks++;
        if (rd_enable_o !== 1'b1 || stall_req_o !== 1'b0 || ram_req_o !== 1'b0) begin failures++; $display("[TB] FAIL pass_ctrl actual=%b%b%b expected=100", rd_enable_o, stall_req_o, ram_req_o); end
        #1 applyStimulus(1'b0, 1'b0, LS_NOP, 32'h0, 32'hCAFEF00D, 5'd31, 1'b0, 1'b0);
        #1;
        checks++;
        if (rd_data_o !== 32'hCAFEF00D || rd_addr_o !== 5'd31 || rd_enable_o !== 1'b0) begin failures++; $display("[TB] FAIL pass_noen actual=%h/%0d/%b expected=cafef00d/31/0", rd_data_o, rd_addr_o, rd_enable_o); end
    endtask

    task automatic test_store_word();
        int stalls; logic [31:0] d; logic [4:0] a; logic en; logic to;
        int base;
        logic [31:0] expAddr [0:3];
        logic [7:0]  expData [0:3];
        expAddr = '{32'h100, 32'h101, 32'h102, 32'h103};
        expData = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        base = writeCount;
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b1, LS_SW, 32'h100, 32'hA1B2C3D4, 5'd3, 1'b1, 1'b1);
        waitDone(stalls, d, a, en, to);
        checks++;
        if (stalls != 5) begin failures++; $display("[TB] FAIL sw_stall actual=%0d expected=5", stalls); end
        checks++;
        if (en !== 1'b0) begin failures++; $display("[TB] FAIL sw_rd_enable actual=%b expected=0", en); end
        checks++;
        if (writeCount - base != 4) begin failures++; $display("[TB] FAIL sw_write_count actual=%0d expected=4", writeCount - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (writeAddr[base+i] !== expAddr[i] || writeData[base+i] !== expData[i]) begin
                failures++;
                $display("[TB] FAIL sw_write%0d actual=%h:%h expected=%h:%h", i, writeAddr[base+i], writeData[base+i], expAddr[i], expData[i]);
            end
        end
        idle();
    endtask

    task automatic test_load_byte();
        int stalls; logic [31:0] d; logic [4:0] a; logic en; logic to;
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, LS_LB, 32'h200, 32'h0, 5'd7, 1'b1, 1'b1);
        waitDone(stalls, d, a, en, to);
        checks++;
        if (stalls != 3) begin failures++; $display("[TB] FAIL lb_stall actual=%0d expected=3", stalls); end
        checks++;
        if (d !== 32'hFFFFFF80 || en !== 1'b1 || a !== 5'd7) begin failures++; $display("[TB] FAIL lb_result actual=%h/%b/%0d expected=ffffff80/1/7", d, en, a); end
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, LS_LBU, 32'h200, 32'h0, 5'd8, 1'b1, 1'b1);
        waitDone(stalls, d, a, en, to);
        checks++;
        if (d !== 32'h00000080 || stalls != 3) begin failures++; $display("[TB] FAIL lbu_result actual=%h/%0d expected=00000080/3", d, stalls); end
        idle();
    endtask

    task automatic test_load_half_wrap();
        int stalls; logic [31:0] d; logic [4:0] a; logic en; logic to;
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, LS_LH, 32'hFFFFFFFF, 32'h0, 5'd2, 1'b1, 1'b1);
        waitDone(stalls, d, a, en, to);
        checks++;
        if (stalls != 4) begin failures++; $display("[TB] FAIL lh_stall actual=%0d expected=4", stalls); end
        checks++;
        if (d !== 32'hFFFF9234) begin failures++; $display("[TB] FAIL lh_wrap_result actual=%h expected=ffff9234", d); end
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, LS_LHU, 32'hFFFFFFFF, 32'h0, 5'd2, 1'b1, 1'b1);
        waitDone(stalls, d, a, en, to);
        checks++;
        if (d !== 32'h00009234) begin failures++; $display("[TB] FAIL lhu_wrap_result actual=%h expected=00009234", d); end
        idle();
    endtask

    task automatic test_grant_wait();
        int stalls; logic [31:0] d; logic [4:0] a; logic en; logic to;
        int base;
        base = writeCount;
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, LS_LW, 32'h300, 32'h0, 5'd12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (stall_req_o !== 1'b1 || ram_req_o !== 1'b1 || ram_wr_o !== 1'b0 || rd_enable_o !== 1'b0 || ram_addr_o !== 32'h300) begin
                failures++;
                $display("[TB] FAIL grant_wait%0d actual=stall%b req%b wr%b en%b addr%h expected=stall1 req1 wr0 en0 addr00000300",
                         i, stall_req_o, ram_req_o, ram_wr_o, rd_enable_o, ram_addr_o);
            end
        end
        @(posedge clk);
        #1 ram_grant_i = 1'b1;
        waitDone(stalls, d, a, en, to);
        checks++;
        if (stalls != 6) begin failures++; $display("[TB] FAIL lw_stall actual=%0d expected=6", stalls); end
        checks++;
        if (d !== 32'h84332211 || en !== 1'b1 || a !== 5'd12) begin failures++; $display("[TB] FAIL lw_result actual=%h/%b/%0d expected=84332211/1/12", d, en, a); end
        checks++;
        if (writeCount != base) begin failures++; $display("[TB] FAIL lw_no_writes actual=%0d expected=%0d", writeCount, base); end
        idle();
    endtask

    task automatic test_reset_mid_store();
        int base;
        base = writeCount;
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b1, LS_SW, 32'h400, 32'h55667788, 5'd0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h402 || ram_dout_o !== 8'h66) begin failures++; $display("[TB] FAIL rst_pre_write actual=%b/%h/%h expected=1/00000402/66", ram_wr_o, ram_addr_o, ram_dout_o); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ram_wr_o !== 1'b0 || ram_req_o !== 1'b0 || stall_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_immediate actual=wr%b req%b stall%b expected=wr0 req0 stall0", ram_wr_o, ram_req_o, stall_req_o); end
        @(posedge clk);
        #1 ram_grant_i = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (stall_req_o !== 1'b1 || ram_req_o !== 1'b1 || ram_wr_o !== 1'b0 || ram_addr_o !== 32'h400) begin failures++; $display("[TB] FAIL rst_idle_after actual=stall%b req%b wr%b addr%h expected=stall1 req1 wr0 addr00000400", stall_req_o, ram_req_o, ram_wr_o, ram_addr_o); end
        checks++;
        if (writeCount - base != 2) begin failures++; $display("[TB] FAIL rst_write_count actual=%0d expected=2", writeCount - base); end
        checks++;
        if (writeData[base] !== 8'h88 || writeData[base+1] !== 8'h77 || writeAddr[base+1] !== 32'h401) begin failures++; $display("[TB] FAIL rst_written_bytes actual=%h,%h@%h expected=88,77@00000401", writeData[base], writeData[base+1], writeAddr[base+1]); end
        idle();
    endtask

    task automatic test_back_to_back();
        int stalls; logic [31:0] d; logic [4:0] a; logic en; logic to;
        int base;
        base = writeCount;
        @(posedge clk);
        #1 applyStimulus(1'b0, 1'b1, LS_SB, 32'h500, 32'h123456AB, 5'd4, 1'b1, 1'b1);
        waitDone(stalls, d, a, en, to);
        checks++;
        if (stalls != 2 || en !== 1'b0) begin failures++; $display("[TB] FAIL sb_done actual=%0d/%b expected=2/0", stalls, en); end
        @(posedge clk);
        #1 applyStimulus(1'b1, 1'b0, LS_LBU, 32'h500, 32'h0, 5'd6, 1'b1, 1'b1);
        #1;
        checks++;
        if (stall_req_o !== 1'b1 || ram_req_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_next_idle actual=stall%b req%b expected=stall1 req1", stall_req_o, ram_req_o); end
        waitDone(stalls, d, a, en, to);
        checks++;
        if (stalls != 3 || d !== 32'h000000AB || en !== 1'b1 || a !== 5'd6) begin failures++; $display("[TB] FAIL b2b_load actual=%0d/%h/%b/%0d expected=3/000000ab/1/6", stalls, d, en, a); end
        checks++;
        if (writeCount - base != 1) begin failures++; $display("[TB] FAIL sb_write_count actual=%0d expected=1", writeCount - base); end
        idle();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_store_word();
        test_load_byte();
        test_load_half_wrap();
        test_grant_wait();
        test_reset_mid_store();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
